// File: rtl/morse_disp_pkg.sv
// Shared types and constants for the Morse display scheduler.
package morse_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
`ifdef MORSE_DISPLAY_CLEAR_EN
        , ST_CLEAR
`endif
    } state_t;

    localparam logic [7:0] ASCII_SPACE    = 8'h20;
    localparam int unsigned DISPLAY_DIGITS = 6;

endpackage

// File: rtl/morse_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on contention the
// requester that was not granted last wins.
module morse_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/morse_display_scheduler.sv
// Schedules characters from two requesters (plus an optional blank-all clear)
// onto a 6-digit display write port. Clear support: MORSE_DISPLAY_CLEAR_EN.
//   state | meaning
//   IDLE  | arbitrate: pending clear first, else round-robin requesters
//   ISSUE | one-cycle write strobe of the captured character
//   GAP   | GAP_CYCLES quiet cycles before the next grant
//   CLEAR | six consecutive strobes of a space
module morse_display_scheduler
    import morse_disp_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_char,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_char,
    output logic       req1_ready,
    input  logic       clear_req,
    output logic [7:0] ascii_char,
    output logic       char_valid,
    output logic       busy
);

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rr_last_q, rr_last_d;
    logic        char_valid_q, char_valid_d;
    logic [7:0]  ascii_q, ascii_d;
    logic [1:0]  grant;
    logic        clear_pend;
    logic        in_idle;

    morse_rr_arb2 u_arb (
        .valid_i ({req1_valid, req0_valid}),
        .last_i  (rr_last_q),
        .grant_o (grant)
    );

    assign in_idle = (state_q == ST_IDLE);

`ifdef MORSE_DISPLAY_CLEAR_EN
    localparam logic [15:0] CLR_LOAD = 16'(DISPLAY_DIGITS - 1);
    logic pend_q, pend_d;
    // A clear arriving in IDLE is served straight away, ahead of any requester.
    assign clear_pend = pend_q | clear_req;
    assign busy       = !in_idle | pend_q;
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req;
    assign clear_pend       = 1'b0;
    assign busy             = !in_idle;
`endif

    assign req0_ready = in_idle & ~clear_pend & grant[0];
    assign req1_ready = in_idle & ~clear_pend & grant[1];
    assign ascii_char = ascii_q;
    assign char_valid = char_valid_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_last_d    = rr_last_q;
        char_valid_d = 1'b0;
        ascii_d      = ascii_q;
`ifdef MORSE_DISPLAY_CLEAR_EN
        pend_d       = pend_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef MORSE_DISPLAY_CLEAR_EN
                if (clear_pend) begin
                    state_d      = ST_CLEAR;
                    char_valid_d = 1'b1;
                    ascii_d      = ASCII_SPACE;
                    cnt_d        = CLR_LOAD;
                    pend_d       = 1'b0;
                end else
`endif
                if (|grant) begin
                    state_d      = ST_ISSUE;
                    char_valid_d = 1'b1;
                    ascii_d      = grant[1] ? req1_char : req0_char;
                    rr_last_d    = grant[1];
                end
            end
            ST_ISSUE: begin
                state_d = ST_GAP;
                cnt_d   = GAP_LOAD;
`ifdef MORSE_DISPLAY_CLEAR_EN
                if (clear_req) pend_d = 1'b1;
`endif
            end
            ST_GAP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
`ifdef MORSE_DISPLAY_CLEAR_EN
                if (clear_req) pend_d = 1'b1;
`endif
            end
`ifdef MORSE_DISPLAY_CLEAR_EN
            // The counter tracks strobes still to go after the current one.
            ST_CLEAR: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d        = cnt_q - 16'd1;
                    char_valid_d = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            rr_last_q    <= 1'b1;
            char_valid_q <= 1'b0;
            ascii_q      <= ASCII_SPACE;
`ifdef MORSE_DISPLAY_CLEAR_EN
            pend_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_last_q    <= rr_last_d;
            char_valid_q <= char_valid_d;
            ascii_q      <= ascii_d;
`ifdef MORSE_DISPLAY_CLEAR_EN
            pend_q       <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_morse_display_scheduler.sv
// Directed bench for morse_display_scheduler with GAP_CYCLES=4; clear scenarios
// follow MORSE_DISPLAY_CLEAR_EN, otherwise the disabled-clear behaviour is checked.
module tb_morse_display_scheduler;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_char = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_char = 8'h00;
    logic       req1_ready;
    logic       clear_req = 1'b0;
    logic [7:0] ascii_char;
    logic       char_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    morse_display_scheduler #(.GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_char  (req0_char),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_char  (req1_char),
        .req1_ready (req1_ready),
        .clear_req  (clear_req),
        .ascii_char (ascii_char),
        .char_valid (char_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 with the DUT in IDLE.
    task automatic apply_reset;
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        clear_req  = 1'b0;
        req0_char  = 8'h00;
        req1_char  = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (char_valid !== 1'b0) begin errors++; $display("FAIL reset_char_valid: got %b, expected 0", char_valid); end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got r0=%b r1=%b, expected 0 0", req0_ready, req1_ready);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++;
        if (ascii_char !== 8'h20) begin errors++; $display("FAIL reset_ascii: got %h, expected 20", ascii_char); end
    endtask

    task automatic test_single_char;
        apply_reset();
        req0_valid = 1'b1;
        req0_char  = 8'h45;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || char_valid !== 1'b0) begin
            errors++; $display("FAIL single_grant: got r0=%b r1=%b cv=%b, expected 1 0 0", req0_ready, req1_ready, char_valid);
        end
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (char_valid !== 1'b1 || ascii_char !== 8'h45 || busy !== 1'b1) begin
            errors++; $display("FAIL single_strobe: got cv=%b ch=%h busy=%b, expected 1 45 1", char_valid, ascii_char, busy);
        end
        for (int i = 0; i < GAP; i++) begin
            next_cycle();
            req0_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (char_valid !== 1'b0 || ascii_char !== 8'h45 || busy !== 1'b1 || req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_gap%0d: got cv=%b ch=%h busy=%b r0=%b, expected 0 45 1 0",
                         i, char_valid, ascii_char, busy, req0_ready);
            end
        end
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || char_valid !== 1'b0) begin
            errors++; $display("FAIL single_idle: got busy=%b cv=%b, expected 0 0", busy, char_valid);
        end
    endtask

    task automatic test_round_robin;
        logic       exp_v, exp_r0, exp_r1;
        logic [7:0] exp_c;
        apply_reset();
        req0_valid = 1'b1; req0_char = 8'h41;
        req1_valid = 1'b1; req1_char = 8'h42;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            exp_v  = (k % 6 == 1);
            exp_c  = ((k / 6) % 2 == 0) ? 8'h41 : 8'h42;
            exp_r0 = (k % 12 == 0);
            exp_r1 = (k % 12 == 6);
            checks++;
            if (char_valid !== exp_v || (exp_v && ascii_char !== exp_c) ||
                req0_ready !== exp_r0 || req1_ready !== exp_r1) begin
                errors++;
                $display("FAIL rr_k%0d: got cv=%b ch=%h r0=%b r1=%b, expected cv=%b ch=%h r0=%b r1=%b",
                         k, char_valid, ascii_char, req0_ready, req1_ready, exp_v, exp_c, exp_r0, exp_r1);
            end
            next_cycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

`ifdef MORSE_DISPLAY_CLEAR_EN
    // Clear coincident with req0 wins; a second clear during CLEAR is dropped.
    task automatic test_clear_idle;
        logic       exp_v, exp_r0, exp_b;
        logic [7:0] exp_c;
        apply_reset();
        for (int k = 0; k <= 12; k++) begin
            if (k == 0) begin clear_req = 1'b1; req0_valid = 1'b1; req0_char = 8'h53; end
            if (k == 1) clear_req = 1'b0;
            if (k == 3) clear_req = 1'b1;
            if (k == 4) clear_req = 1'b0;
            if (k == 12) req0_valid = 1'b0;
            @(negedge clk);
            exp_r0 = (k == 11);
            exp_v  = (k >= 1 && k <= 6) || k == 12;
            exp_c  = (k == 12) ? 8'h53 : 8'h20;
            exp_b  = (k >= 1 && k <= 10) || k == 12;
            checks++;
            if (char_valid !== exp_v || (exp_v && ascii_char !== exp_c) ||
                req0_ready !== exp_r0 || busy !== exp_b) begin
                errors++;
                $display("FAIL clear_idle_k%0d: got cv=%b ch=%h r0=%b busy=%b, expected cv=%b ch=%h r0=%b busy=%b",
                         k, char_valid, ascii_char, req0_ready, busy, exp_v, exp_c, exp_r0, exp_b);
            end
            next_cycle();
        end
    endtask

    task automatic test_clear_in_gap;
        logic       exp_v, exp_r0, exp_r1, exp_b;
        logic [7:0] exp_c;
        apply_reset();
        for (int k = 0; k <= 18; k++) begin
            if (k == 0) begin req0_valid = 1'b1; req0_char = 8'h45; end
            if (k == 1) req0_valid = 1'b0;
            if (k == 2) begin clear_req = 1'b1; req1_valid = 1'b1; req1_char = 8'h4D; end
            if (k == 3) clear_req = 1'b0;
            if (k == 18) req1_valid = 1'b0;
            @(negedge clk);
            exp_r0 = (k == 0);
            exp_r1 = (k == 17);
            exp_v  = (k == 1) || (k >= 7 && k <= 12) || (k == 18);
            exp_c  = (k == 1) ? 8'h45 : ((k == 18) ? 8'h4D : 8'h20);
            exp_b  = !(k == 0 || k == 17);
            checks++;
            if (char_valid !== exp_v || (exp_v && ascii_char !== exp_c) || req0_ready !== exp_r0 ||
                req1_ready !== exp_r1 || busy !== exp_b) begin
                errors++;
                $display("FAIL clear_gap_k%0d: got cv=%b ch=%h r0=%b r1=%b busy=%b, expected cv=%b ch=%h r0=%b r1=%b busy=%b",
                         k, char_valid, ascii_char, req0_ready, req1_ready, busy,
                         exp_v, exp_c, exp_r0, exp_r1, exp_b);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_clear;
        apply_reset();
        clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            checks++;
            if (char_valid !== 1'b1 || ascii_char !== 8'h20) begin
                errors++; $display("FAIL mid_clear_strobe%0d: got cv=%b ch=%h, expected 1 20", s, char_valid, ascii_char);
            end
            if (s < 3) next_cycle();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (char_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_clear_abort: got cv=%b busy=%b, expected 0 0", char_valid, busy);
        end
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (char_valid !== 1'b0 || busy !== 1'b0 || ascii_char !== 8'h20) begin
                errors++;
                $display("FAIL mid_clear_after%0d: got cv=%b busy=%b ch=%h, expected 0 0 20", i, char_valid, busy, ascii_char);
            end
            next_cycle();
        end
    endtask
`else
    task automatic test_clear_disabled;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            clear_req = (k == 0);
            @(negedge clk);
            checks++;
            if (char_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL clear_off_k%0d: got cv=%b busy=%b, expected 0 0", k, char_valid, busy);
            end
            next_cycle();
        end
        clear_req  = 1'b1;
        req0_valid = 1'b1;
        req0_char  = 8'h4B;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL clear_off_ready: got %b, expected 1", req0_ready); end
        next_cycle();
        clear_req  = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (char_valid !== 1'b1 || ascii_char !== 8'h4B) begin
            errors++; $display("FAIL clear_off_strobe: got cv=%b ch=%h, expected 1 4b", char_valid, ascii_char);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_char();
        test_round_robin();
`ifdef MORSE_DISPLAY_CLEAR_EN
        test_clear_idle();
        test_clear_in_gap();
        test_reset_mid_clear();
`else
        test_clear_disabled();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_display_scheduler.md
MORSE_DISPLAY_SCHEDULER -- requirements
Module: morse_display_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16: idle cycles after each issued character; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req0_valid  input  1  decoder requester has a character.
REQ-005 SHALL have port req0_char  input  8  decoder ASCII character.
REQ-006 SHALL have port req0_ready  output  1  decoder character accepted this cycle.
REQ-007 SHALL have port req1_valid  input  1  message/status requester has a character.
REQ-008 SHALL have port req1_char  input  8  message ASCII character.
REQ-009 SHALL have port req1_ready  output  1  message character accepted this cycle.
REQ-010 SHALL have port clear_req  input  1  single-cycle request to blank all six digits.
REQ-011 SHALL have port ascii_char  output  8  character to the 6-digit display, registered.
REQ-012 SHALL have port char_valid  output  1  one-cycle write strobe to the display, registered.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE or a clear is pending.

Function
REQ-014 SHALL implement the states IDLE, ISSUE, GAP and CLEAR.
REQ-015 IDLE, pending clear: SHALL enter CLEAR; clear has priority over both requesters.
REQ-016 IDLE, exactly one valid: SHALL assert that requester's ready combinationally in the same cycle, capture its char at the clock edge, and enter ISSUE.
REQ-017 IDLE, both valid: SHALL grant the requester not granted last (round-robin); the pointer updates on each grant.
REQ-018 ISSUE: SHALL drive char_valid=1 with the captured char for exactly one cycle, then enter GAP; handshake-to-strobe latency SHALL be 1 cycle.
REQ-019 GAP: SHALL count GAP_CYCLES cycles with char_valid=0 and both readies 0, then enter IDLE; minimum strobe spacing SHALL be GAP_CYCLES+2 cycles.
REQ-020 readyN SHALL be 1 only in IDLE with no pending clear and reqN granted; a requester SHALL hold valid/char stable until ready.
REQ-021 Outside ISSUE/CLEAR strobes, char_valid SHALL be 0 and ascii_char SHALL hold its last value.
REQ-022 clear_req received in ISSUE or GAP SHALL be latched as pending and served at the next IDLE.
REQ-023 CLEAR: SHALL emit six strobes with ascii_char=8'h20 on six consecutive cycles, then enter GAP; the display's 6-entry write index therefore returns to its start position.
REQ-024 clear_req received while in CLEAR SHALL be ignored.
REQ-025 A clear_req coincident with a requester's valid in IDLE SHALL take priority; no ready is asserted in that cycle.

Reset
REQ-026 On reset, the block SHALL go to IDLE.
REQ-027 On reset, char_valid, req0_ready, req1_ready and busy SHALL be 0, ascii_char SHALL be 8'h20, and the clear-pending flag and GAP counter SHALL be 0.
REQ-028 On reset, the round-robin pointer SHALL be set so that req0 wins the first contention.
REQ-029 Reset mid-CLEAR or mid-GAP SHALL abort immediately; the partial sequence is not resumed.

Configuration
REQ-030 SHALL use macro MORSE_DISPLAY_CLEAR_EN.
REQ-031 With MORSE_DISPLAY_CLEAR_EN defined: clear_req, the pending flag and the CLEAR state SHALL be implemented as specified.
REQ-032 Without MORSE_DISPLAY_CLEAR_EN: the clear_req port SHALL remain but be ignored, the CLEAR state and pending flag SHALL be absent, and busy SHALL equal (state != IDLE).

Structure
REQ-033 Shared package morse_disp_pkg SHALL hold the state enum, ASCII_SPACE=8'h20 and DISPLAY_DIGITS=6.
REQ-034 Two-way round-robin grant logic SHALL be sub-module morse_rr_arb2 (inputs: valids and pointer; outputs: one-hot grant).

Verification (GAP_CYCLES=4)
REQ-035 req0 sends "E" (8'h45) at cycle 10 -> req0_ready=1 at 10, char_valid with 8'h45 at 11, IDLE again at 16.
REQ-036 req0 and req1 both valid continuously after reset -> grant order req0, req1, req0, req1, with strobes spaced 6 cycles apart.
REQ-037 clear_req pulse in IDLE -> six consecutive strobes of 8'h20, then 4 gap cycles, busy=1 throughout.
REQ-038 clear_req during GAP while req1 is valid -> clear served first, req1_ready asserted only after the clear's gap.
REQ-039 reset asserted at the 3rd clear strobe -> char_valid=0 and IDLE on the next cycle, ascii_char=8'h20.
REQ-040 Build without MORSE_DISPLAY_CLEAR_EN, pulse clear_req -> no strobes and busy stays 0.
